vga_fetch: RTL

Framebuffer prefetch engine directly upstream of the pixel FIFO. On each frame start it reads the frame's words from video memory over a Wishbone-classic master port. Whenever the FIFO reports less-than-half-full, it pushes a burst of words into the FIFO. Each push is a single-cycle pulse separated by a low cycle, because the FIFO acts on the rising edge of push.

---
 rtl/vga_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vga_fetch.sv
// Framebuffer prefetch: reads frame words over Wishbone-classic and pushes them into the pixel FIFO.
// Push 1 cycle after ack, min 3 cycles/word; refills only while FIFO is below half, stops at full in WAIT/GAP.
module vga_fetch #(
    parameter int          WIDTH       = 32,
    parameter int          ADDR_WIDTH  = 24,
    parameter int unsigned BASE        = 0,
    parameter int          FRAME_WORDS = 9600,
    parameter int          BURST       = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_frame_start,
    input  logic                  i_fifo_half,
    input  logic                  i_fifo_full,
    output logic [WIDTH-1:0]      o_fifo_dat,
    output logic                  o_fifo_push,
    output logic [ADDR_WIDTH-1:0] o_wb_adr,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    input  logic                  i_wb_ack,
    input  logic [WIDTH-1:0]      i_wb_dat,
    output logic                  o_busy
);

    // One extra count value so the counters can hold FRAME_WORDS and BURST themselves.
    localparam int IDX_W = $clog2(FRAME_WORDS + 1);
    localparam int BC_W  = $clog2(BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_PUSH,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] word_idx;
    logic [BC_W-1:0]  burst_cnt;
    logic             restart;
    logic             wb_req;

    assign o_wb_cyc = wb_req;
    assign o_wb_stb = wb_req;
    assign o_wb_we  = 1'b0;
    assign o_wb_adr = ADDR_WIDTH'(BASE) + ADDR_WIDTH'(word_idx);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            word_idx    <= '0;
            burst_cnt   <= '0;
            restart     <= 1'b0;
            wb_req      <= 1'b0;
            o_fifo_dat  <= '0;
            o_fifo_push <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_fifo_push <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_frame_start) begin
                        word_idx <= '0;
                        state    <= S_WAIT;
                        o_busy   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_frame_start) begin
                        word_idx <= '0;
                    end else if (i_fifo_half && !i_fifo_full) begin
                        burst_cnt <= '0;
                        wb_req    <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_wb_ack) begin
                        wb_req <= 1'b0;
                        // A frame restart seen during this bus cycle discards its data.
                        if (restart || i_frame_start) begin
                            word_idx <= '0;
                            restart  <= 1'b0;
                            state    <= S_WAIT;
                        end else begin
                            o_fifo_dat  <= i_wb_dat;
                            o_fifo_push <= 1'b1;
                            state       <= S_PUSH;
                        end
                    end else if (i_frame_start) begin
                        restart <= 1'b1;
                    end
                end
                S_PUSH: begin
                    if (i_frame_start) begin
                        word_idx <= '0;
                        state    <= S_WAIT;
                    end else begin
                        word_idx  <= word_idx + 1'b1;
                        burst_cnt <= burst_cnt + 1'b1;
                        state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (i_frame_start) begin
                        word_idx <= '0;
                        state    <= S_WAIT;
                    end else if (word_idx == IDX_W'(FRAME_WORDS)) begin
                        state  <= S_DONE;
                        o_busy <= 1'b0;
                    end else if (burst_cnt == BC_W'(BURST) || i_fifo_full) begin
                        state <= S_WAIT;
                    end else begin
                        wb_req <= 1'b1;
                        state  <= S_REQ;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    wb_req <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
